// File: rtl/bit_selection_window_ctrl.sv
// Window sequencer for bit_selection_32x16_seq: streams words into the selector with a stepping select command.
// Build option BIT_SEL_OFFSET_SATURATE_EN: offset saturates at its maximum instead of wrapping.
module bit_selection_window_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int COMMAND_WIDTH = 4,
    parameter int COUNT_WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [COMMAND_WIDTH-1:0] cfg_offset,
    input  logic [COMMAND_WIDTH-1:0] cfg_stride,
    input  logic [COUNT_WIDTH-1:0]   cfg_len,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_WIDTH-1:0]    s_data,
    input  logic                     i_stall,
    input  logic                     i_abort,
    output logic                     o_sel_en,
    output logic                     o_sel_valid,
    output logic [COMMAND_WIDTH-1:0] o_sel_cmd,
    output logic [DATA_WIDTH-1:0]    o_sel_data,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [1:0]               o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [COMMAND_WIDTH-1:0] off_q, off_d;
    logic [COMMAND_WIDTH-1:0] stride_q, stride_d;
    logic [COUNT_WIDTH-1:0]   rem_q, rem_d;
    logic                     sel_valid_q, sel_valid_d;
    logic [COMMAND_WIDTH-1:0] sel_cmd_q, sel_cmd_d;
    logic [DATA_WIDTH-1:0]    sel_data_q, sel_data_d;
    logic                     done_q, done_d;

    logic                     cfg_hs;
    logic                     word_hs;
    logic [COMMAND_WIDTH:0]   off_sum;
    logic [COMMAND_WIDTH-1:0] off_next;

    // Both ports transfer on the rising edge where valid & ready; valid must not depend on ready.
    // i_abort wins over everything, so a word beat offered with it is refused via s_ready.
    assign cfg_ready   = (state_q == ST_IDLE);
    assign s_ready     = (state_q == ST_RUN) & ~i_stall & ~i_abort;
    assign cfg_hs      = cfg_valid & cfg_ready;
    assign word_hs     = s_valid & s_ready;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_dbg_state = state_q;
    assign o_sel_en    = sel_valid_q;
    assign o_sel_valid = sel_valid_q;
    assign o_sel_cmd   = sel_cmd_q;
    assign o_sel_data  = sel_data_q;
    assign o_done      = done_q;

    assign off_sum = {1'b0, off_q} + {1'b0, stride_q};
`ifdef BIT_SEL_OFFSET_SATURATE_EN
    assign off_next = off_sum[COMMAND_WIDTH] ? {COMMAND_WIDTH{1'b1}} : off_sum[COMMAND_WIDTH-1:0];
`else
    assign off_next = off_sum[COMMAND_WIDTH-1:0];
`endif

    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        stride_d    = stride_q;
        rem_d       = rem_q;
        sel_valid_d = 1'b0;
        sel_cmd_d   = sel_cmd_q;
        sel_data_d  = sel_data_q;
        done_d      = 1'b0;
        if (i_abort) begin
            state_d = ST_IDLE;
            rem_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg_hs) begin
                        off_d    = cfg_offset;
                        stride_d = cfg_stride;
                        rem_d    = cfg_len;
                        state_d  = (cfg_len == '0) ? ST_DRAIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (word_hs) begin
                        sel_valid_d = 1'b1;
                        sel_cmd_d   = off_q;
                        sel_data_d  = s_data;
                        off_d       = off_next;
                        rem_d       = rem_q - 1'b1;
                        if (rem_q == COUNT_WIDTH'(1)) state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Lines up with the selector's registered output of the final word.
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            off_q       <= '0;
            stride_q    <= '0;
            rem_q       <= '0;
            sel_valid_q <= 1'b0;
            sel_cmd_q   <= '0;
            sel_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            stride_q    <= stride_d;
            rem_q       <= rem_d;
            sel_valid_q <= sel_valid_d;
            sel_cmd_q   <= sel_cmd_d;
            sel_data_q  <= sel_data_d;
            done_q      <= done_d;
        end
    end

endmodule
